// File: rtl/lc3_pkg.sv
// Shared LC-3 operand-fetch definitions: FSM states, widths, IR field positions and SEXT.
package lc3_pkg;
  localparam int DATA_W      = 16;
  localparam int IMM_W       = 5;
  localparam int NUM_REGS    = 8;
  localparam int IDX_W       = 3;
  localparam int SR1_LSB     = 6;
  localparam int SR2_LSB     = 0;
  localparam int IMM_SEL_BIT = 5;

  typedef enum logic [1:0] {IDLE, READ, VALID} ofu_state_e;

  function automatic logic [DATA_W-1:0] sext(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction
endpackage

// File: rtl/operand_fetch_unit_if.sv
// Instruction, register-write and operand handshake bundle of the operand fetch unit.
interface operand_fetch_unit_if import lc3_pkg::*; #(
  parameter int DATA_W = lc3_pkg::DATA_W
);
  logic [15:0]       IR;
  logic              LD_REG;
  logic [IDX_W-1:0]  DR;
  logic [DATA_W-1:0] Bus_In;
  logic              Fetch_Req;
  logic              Operand_Ack;
  logic              Busy;
  logic              Operand_Valid;
  logic [DATA_W-1:0] SR1_OUT;
  logic [DATA_W-1:0] SR2_OUT;
  logic [DATA_W-1:0] Imm_OUT;
  logic              Imm_Sel;

  modport master (
    output IR, LD_REG, DR, Bus_In, Fetch_Req, Operand_Ack,
    input  Busy, Operand_Valid, SR1_OUT, SR2_OUT, Imm_OUT, Imm_Sel
  );

  modport slave (
    input  IR, LD_REG, DR, Bus_In, Fetch_Req, Operand_Ack,
    output Busy, Operand_Valid, SR1_OUT, SR2_OUT, Imm_OUT, Imm_Sel
  );
endinterface

// File: rtl/reg_file_8x16.sv
// LC-3 general register file: one write port, two combinational read ports, async clear.
module reg_file_8x16 #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];
endmodule

// File: rtl/operand_fetch_unit.sv
// LC-3 register file with IDLE/READ/VALID operand staging toward the ALU stage.
// Optional write-through forwarding in READ under macro OFU_WRITE_BYPASS_EN.
module operand_fetch_unit import lc3_pkg::*; #(
  parameter int DATA_W   = lc3_pkg::DATA_W,
  parameter int NUM_REGS = lc3_pkg::NUM_REGS,
  parameter int IMM_W    = lc3_pkg::IMM_W
) (
  input logic                 Clk,
  input logic                 Reset,
  operand_fetch_unit_if.slave bus
);
  ofu_state_e        state_q, state_d;
  logic [IDX_W-1:0]  sr1_idx_q, sr1_idx_d;
  logic [IDX_W-1:0]  sr2_idx_q, sr2_idx_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] sr1_q, sr1_d;
  logic [DATA_W-1:0] sr2_q, sr2_d;
  logic [DATA_W-1:0] immx_q, immx_d;
  logic              imm_sel_q, imm_sel_d;
  logic [DATA_W-1:0] rd1, rd2;

  reg_file_8x16 #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (IDX_W)
  ) u_rf (
    .clk     (Clk),
    .rst     (Reset),
    .we_i    (bus.LD_REG),
    .waddr_i (bus.DR),
    .wdata_i (bus.Bus_In),
    .raddr1_i(sr1_idx_q),
    .raddr2_i(sr2_idx_q),
    .rdata1_o(rd1),
    .rdata2_o(rd2)
  );

  always_comb begin
    state_d   = state_q;
    sr1_idx_d = sr1_idx_q;
    sr2_idx_d = sr2_idx_q;
    imm_d     = imm_q;
    sel_d     = sel_q;
    sr1_d     = sr1_q;
    sr2_d     = sr2_q;
    immx_d    = immx_q;
    imm_sel_d = imm_sel_q;
    case (state_q)
      IDLE: begin
        if (bus.Fetch_Req) begin
          sr1_idx_d = bus.IR[SR1_LSB +: IDX_W];
          sr2_idx_d = bus.IR[SR2_LSB +: IDX_W];
          imm_d     = bus.IR[IMM_W-1:0];
          sel_d     = bus.IR[IMM_SEL_BIT];
          state_d   = READ;
        end
      end
      READ: begin
        sr1_d     = rd1;
        sr2_d     = rd2;
`ifdef OFU_WRITE_BYPASS_EN
        // A write landing on this same edge is forwarded so the consumer sees the newest value.
        if (bus.LD_REG && (bus.DR == sr1_idx_q)) sr1_d = bus.Bus_In;
        if (bus.LD_REG && (bus.DR == sr2_idx_q)) sr2_d = bus.Bus_In;
`endif
        immx_d    = sext(imm_q);
        imm_sel_d = sel_q;
        state_d   = VALID;
      end
      VALID: begin
        if (bus.Operand_Ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      sr1_idx_q <= '0;
      sr2_idx_q <= '0;
      imm_q     <= '0;
      sel_q     <= 1'b0;
      sr1_q     <= '0;
      sr2_q     <= '0;
      immx_q    <= '0;
      imm_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr1_idx_q <= sr1_idx_d;
      sr2_idx_q <= sr2_idx_d;
      imm_q     <= imm_d;
      sel_q     <= sel_d;
      sr1_q     <= sr1_d;
      sr2_q     <= sr2_d;
      immx_q    <= immx_d;
      imm_sel_q <= imm_sel_d;
    end
  end

  assign bus.Busy          = (state_q != IDLE);
  assign bus.Operand_Valid = (state_q == VALID);
  assign bus.SR1_OUT       = sr1_q;
  assign bus.SR2_OUT       = sr2_q;
  assign bus.Imm_OUT       = immx_q;
  assign bus.Imm_Sel       = imm_sel_q;
endmodule
